// File: rtl/set_assoc_cache.sv
// N-way set-associative read cache, true-LRU victims, multi-beat line refill over valid/ready.
// Hit: resp 2 cycles after accept; miss: 3 + mem stall + beats. One request in flight; no resp backpressure.
module set_assoc_cache #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 16,
    parameter int WAYS           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int WIDX_W = $clog2(WORDS_PER_LINE);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - WIDX_W - SET_W;
    localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W  = AGE_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH
    } state_t;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    function automatic ages_t age_init();
        ages_t a;
        for (int i = 0; i < WAYS; i++) a[i] = AGE_W'(i);
        return a;
    endfunction

    localparam ages_t AGE_INIT = age_init();

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_flush_pend;
    logic [WAYS-1:0]     r_valid [NUM_SETS];
    ages_t               r_age   [NUM_SETS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][WAYS];
    logic [DATA_W-1:0]   r_data  [NUM_SETS][WAYS][WORDS_PER_LINE];
    logic [WAY_W-1:0]    r_victim;
    logic [WIDX_W-1:0]   r_beat;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_hit;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_mem_req_valid;
    logic [ADDR_W-1:0]   r_mem_req_addr;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [SET_W-1:0]    w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [WIDX_W-1:0]   w_widx;
    logic [WAYS-1:0]     w_valid_cur;
    ages_t               w_age_cur;
    ages_t               w_age_next;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [WAY_W-1:0]    w_victim;
    logic [WAY_W-1:0]    w_acc_way;
    logic                w_last_beat;
    logic                w_unused;

    assign w_set       = r_addr[OFF_W + WIDX_W +: SET_W];
    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_widx      = r_addr[OFF_W +: WIDX_W];
    assign w_valid_cur = r_valid[w_set];
    assign w_age_cur   = r_age[w_set];
    assign w_last_beat = (r_beat == WIDX_W'(WORDS_PER_LINE - 1));
    assign w_unused    = ^{1'b0, r_addr};

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_valid_cur[w] && r_tag[w_set][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        // Oldest way first, then overridden by the lowest-index invalid way.
        w_victim = '0;
        for (int w = 1; w < WAYS; w++) begin
            if (w_age_cur[w] > w_age_cur[w_victim]) w_victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_valid_cur[w]) w_victim = WAY_W'(w);
        end
    end

    always_comb begin
        w_acc_way  = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
        w_age_next = w_age_cur;
        if (WAYS > 1) begin
            for (int i = 0; i < WAYS; i++) begin
                if (w_age_cur[i] < w_age_cur[w_acc_way]) w_age_next[i] = w_age_cur[i] + 1'b1;
            end
            w_age_next[w_acc_way] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && mem_resp_valid) begin
            r_data[w_set][r_victim][r_beat] <= mem_resp_data;
            if (w_last_beat) r_tag[w_set][r_victim] <= w_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_flush_pend    <= 1'b0;
            r_valid         <= '{default: '0};
            r_age           <= '{default: AGE_INIT};
            r_victim        <= '0;
            r_beat          <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_data     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
        end else begin
            if (flush) r_flush_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_flush_pend) begin
                        r_state     <= S_FLUSH;
                        r_req_ready <= 1'b0;
                    end else if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_state     <= S_LOOKUP;
                        r_req_ready <= 1'b0;
                    end else begin
                        r_req_ready <= !flush;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_hit_count  <= r_hit_count + 32'd1;
                        r_age[w_set] <= w_age_next;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_data  <= r_data[w_set][w_hit_way][w_widx];
                        r_state      <= S_RESPOND;
                    end else begin
                        r_miss_count    <= r_miss_count + 32'd1;
                        r_victim        <= w_victim;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= {w_tag, w_set, {(WIDX_W + OFF_W){1'b0}}};
                        r_state         <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_beat          <= '0;
                        r_state         <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_resp_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_widx) r_resp_data <= mem_resp_data;
                        if (w_last_beat) begin
                            r_valid[w_set][r_victim] <= 1'b1;
                            r_age[w_set]             <= w_age_next;
                            r_resp_valid             <= 1'b1;
                            r_resp_hit               <= 1'b0;
                            r_state                  <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= !(r_flush_pend || flush);
                    r_state      <= S_IDLE;
                end
                S_FLUSH: begin
                    r_valid      <= '{default: '0};
                    r_age        <= '{default: AGE_INIT};
                    r_flush_pend <= flush;
                    r_req_ready  <= !flush;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: expected responses queued at issue, checked by a response monitor.
module tb_set_assoc_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    set_assoc_cache dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                timeout("unexpected_resp");
            end else begin
                e = q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
            end
        end
    end

    task automatic check_reset();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
    endtask

    task automatic chk_counts();
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
    endtask

    task automatic issue(input logic [31:0] addr, input bit push, input logic [31:0] data, input bit hit);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) timeout("req_ready_wait");
        req_addr  = addr;
        req_valid = 1'b1;
        if (push) begin
            q.push_back('{data: data, hit: hit});
            if (hit) exp_hits++; else exp_misses++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_mreq(input logic [31:0] line);
        int t = 0;
        @(negedge clk);
        while (!mem_req_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!mem_req_valid) timeout("mem_req_wait");
        chk("mem_req_addr", mem_req_addr, line);
    endtask

    task automatic serve(input logic [31:0] line, input logic [31:0] base,
                         input int stall, input int gap, input int flush_beat);
        wait_mreq(line);
        for (int i = 0; i < stall; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD;
            @(negedge clk);
            chk("stall_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("stall_addr", mem_req_addr, line);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat (gap) begin
                @(posedge clk); #1;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + b;
            flush          = (b == flush_beat);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int t = 0;
        @(negedge clk);
        while (!resp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) timeout("resp_wait");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'h1FFFFF17, 1, 32'hA1, 0);
        serve(32'h1FFFFF10, 32'hA0, 0, 0, -1);
        wait_resp();
        chk_counts();

        // Hit: response must appear exactly in the second cycle after accept.
        issue(32'h1FFFFF1C, 1, 32'hA3, 1);
        @(negedge clk);
        chk("hit_lat_cycle1", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("hit_lat_cycle2", {31'd0, resp_valid}, 32'd1);
        chk("hit_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
        chk_counts();

        issue(32'h2FFFFF14, 1, 32'hB1, 0);
        serve(32'h2FFFFF10, 32'hB0, 5, 2, -1);
        wait_resp();
        issue(32'h1FFFFF10, 1, 32'hA0, 1);
        wait_resp();
        issue(32'h3FFFFF14, 1, 32'hC1, 0);
        serve(32'h3FFFFF10, 32'hC0, 0, 1, -1);
        wait_resp();
        issue(32'h1FFFFF10, 1, 32'hA0, 1);
        wait_resp();
        issue(32'h2FFFFF14, 1, 32'hD1, 0);
        serve(32'h2FFFFF10, 32'hD0, 0, 0, -1);
        wait_resp();
        issue(32'h1FFFFF1C, 1, 32'hA3, 1);
        wait_resp();
        chk_counts();

        // Flush pulsed mid-refill: response first, then two cycles with req_ready low.
        issue(32'h4FFFFF28, 1, 32'hE2, 0);
        serve(32'h4FFFFF20, 32'hE0, 0, 1, 1);
        wait_resp();
        @(negedge clk);
        chk("flush_pending_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("flush_cycle_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("flush_done_ready", {31'd0, req_ready}, 32'd1);
        chk_counts();
        issue(32'h1FFFFF17, 1, 32'hF1, 0);
        serve(32'h1FFFFF10, 32'hF0, 0, 0, -1);
        wait_resp();
        chk_counts();

        // Reset in the middle of a refill: no response, contents lost.
        issue(32'h2FFFFF14, 0, 32'h0, 0);
        wait_mreq(32'h2FFFFF10);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h99;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h1FFFFF17, 1, 32'h51, 0);
        serve(32'h1FFFFF10, 32'h50, 0, 0, -1);
        wait_resp();
        chk_counts();

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative read cache, the successor to the direct-mapped cache top. It accepts word-read requests from the processor side and returns data with a hit/miss flag. Misses are serviced by a multi-beat line refill over a valid/ready memory port, and victims are chosen by true LRU. Running hit and miss counters replace the bench-side miss counting used today.

## Interface

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width, power of two ≥ 8
- WORDS_PER_LINE, 4, words per line, power of two ≥ 2
- NUM_SETS, 16, number of sets, power of two ≥ 2
- WAYS, 2, associativity, power of two ≥ 1

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address
- resp_valid  out  1  one-cycle pulse, no backpressure
- resp_data  out  DATA_W  requested word
- resp_hit  out  1  1 = served from cache, 0 = served after refill
- flush  in  1  level; invalidate all lines
- mem_req_valid  out  1  line fetch request
- mem_req_ready  in  1  memory accepts fetch
- mem_req_addr  out  ADDR_W  line-aligned address
- mem_resp_valid  in  1  refill beat valid
- mem_resp_data  in  DATA_W  refill beat, word 0 first
- hit_count  out  32  hits since reset, wraps at 2^32
- miss_count  out  32  misses since reset, wraps at 2^32

## Operation

- Address split, LSB first:
  - byte offset: log2(DATA_W/8) bits, ignored.
  - word index: log2(WORDS_PER_LINE) bits.
  - set index: log2(NUM_SETS) bits.
  - tag: remaining bits.
  - Defaults give 2/2/4/24 bits.
- Per line: valid bit, tag, and WORDS_PER_LINE words. Per way: log2(WAYS)-bit LRU age; age 0 = most recent.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND, FLUSH.
- IDLE:
  - req_ready=1 unless a flush is pending.
  - Accepting a request registers the address and moves to LOOKUP.
  - A pending flush takes priority over a request: go to FLUSH.
- LOOKUP: compare the tag against all ways of the set.
  - Hit: increment hit_count, update LRU, go to RESPOND with resp_hit=1.
  - Miss: increment miss_count and select a victim. The victim is the lowest-index invalid way; if none is invalid, the way with the maximum age. Go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1; mem_req_addr = request address with word and byte offsets zeroed.
  - Valid and address are held stable until mem_req_ready; then go to REFILL.
- REFILL:
  - Each mem_resp_valid beat writes the victim way at the beat counter's word position, then increments the counter.
  - Gaps between beats are allowed.
  - On the last beat: set valid, write the tag, update LRU, go to RESPOND with resp_hit=0.
- RESPOND: resp_valid=1 for one cycle with the requested word (taken from the captured beat on a miss), then go to IDLE.
- LRU update on access to way w: ways with age < age(w) increment, and w becomes 0.
- Flush:
  - A flush asserted in any state is latched as pending.
  - FLUSH lasts one cycle: it clears all valid bits and sets ages so that way i has age i. It does not touch the counters. Then go to IDLE.
  - A flush during REFILL completes the refill and response first.
- WAYS=1 degenerates to direct-mapped; the LRU logic is absent.

## Timing

- Reset: state IDLE, all valid=0, ages set to way index, counters 0. Outputs req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, mem_req_valid=0, mem_req_addr=0.
- Hit latency: accept at edge N; resp_valid is high during cycle N+2.
- Miss latency: 3 + mem_req stall cycles + beat arrival cycles.
- req_ready is 0 in every state except IDLE, so there is one outstanding request at most.
- mem_resp_valid outside REFILL is ignored.
- Reset mid-operation drops the request with no response and invalidates all contents.

## Test plan

- Reset; read 0x1FFFFF17 → mem_req_addr=0x1FFFFF10; beats 0xA0,0xA1,0xA2,0xA3 → resp_data=0xA1, resp_hit=0, miss_count=1.
- Then read 0x1FFFFF1C → resp_data=0xA3, resp_hit=1 two cycles after accept, no mem_req_valid, hit_count=1.
- Read 0x2FFFFF14 (set 1, miss, fills way 1), then 0x1FFFFF10 (hit), then 0x3FFFFF14 (miss) → the refill evicts the 0x2FFFFF tag; then 0x1FFFFF10 hits and 0x2FFFFF14 misses.
- Hold mem_req_ready=0 for 5 cycles → mem_req_valid and mem_req_addr stable, req_ready=0 throughout. Insert 2-cycle gaps between beats → correct data returned.
- Pulse flush during REFILL → refill and response complete first, one FLUSH cycle follows, then 0x1FFFFF17 misses again with counters preserved.
- Assert rst_n=0 mid-REFILL → all outputs at reset values immediately, and the next read of a previously cached address misses.
